// File: rtl/ecc_secded_encode_pipe_pkg.sv
// ecc_pkg: shared SECDED code helpers, frame offsets and injection modes.
package ecc_pkg;

    typedef enum logic [1:0] {
        INJ_NONE   = 2'd0,
        INJ_SINGLE = 2'd1,
        INJ_DOUBLE = 2'd2
    } inj_mode_e;

    localparam int ECC_HAM_OFS = 0;
    localparam int ECC_FLAG_FROM_TOP = 1;

    function automatic int ecc_parity_count(input int data_w);
        int p = 1;
        for (int i = 0; i < 8; i++) if ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    // Data bits take the non-power-of-2 codeword positions from 3 upward.
    function automatic logic [7:0] ecc_hamming_gen(input logic [63:0] data, input int data_w);
        logic [7:0] h;
        int d;
        h = '0;
        d = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0 && d < data_w) begin
                for (int k = 0; k < 8; k++) if (p[k] && data[d]) h[k] = ~h[k];
                d++;
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/ecc_secded_encode_pipe_stage.sv
// ecc_pipe_stage: single valid/ready register slice.
module ecc_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_aclk,
    input  logic         i_aresetn,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) dn_data <= up_data;
        end
    end

endmodule

// File: rtl/ecc_secded_encode_pipe.sv
// ecc_secded_encode_pipe: 2-stage SECDED encoder with bypass and error injection.
module ecc_secded_encode_pipe import ecc_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ECC_W = 8,
    parameter int CNT_W = 16,
    localparam int P = ecc_parity_count(DATA_W),
    localparam int CW = DATA_W + P + 1,
    localparam int PW = $clog2(CW),
    localparam int FW = DATA_W + ECC_W
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_enable_ecc,
    input  logic              i_wvalid,
    output logic              o_wready,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_wvalid,
    input  logic              i_wready,
    output logic [FW-1:0]     o_wdata,
    input  logic              i_inj_req,
    input  logic [1:0]        i_inj_mode,
    input  logic [PW-1:0]     i_inj_pos,
    output logic              o_inj_armed,
    output logic [CNT_W-1:0]  o_beat_cnt
);

    localparam int S1W = DATA_W + P + 1 + CW;

    logic              inj_armed;
    inj_mode_e         inj_mode_q;
    logic [PW-1:0]     inj_pos_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              accept;
    logic              inject;
    int                pos_a;
    int                pos_b;
    logic [CW-1:0]     mask_in;
    logic              s1_valid;
    logic              s1_ready;
    logic [S1W-1:0]    s1_data;
    logic [DATA_W-1:0] s1_d;
    logic [P-1:0]      s1_h;
    logic              s1_enc;
    logic [CW-1:0]     s1_m;
    logic [FW-1:0]     frame;

    always_comb begin
        accept  = i_wvalid && o_wready;
        inject  = inj_armed && i_enable_ecc;
        pos_a   = int'(inj_pos_q) % CW;
        pos_b   = (pos_a + 1) % CW;
        mask_in = inject ? ((CW'(1) << pos_a) | (inj_mode_q == INJ_DOUBLE ? CW'(1) << pos_b : '0)) : '0;
    end

    ecc_pipe_stage #(.W(S1W)) u_s1 (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .up_valid  (i_wvalid),
        .up_ready  (o_wready),
        .up_data   ({i_wdata, P'(ecc_hamming_gen(64'(i_wdata), DATA_W)), i_enable_ecc, mask_in}),
        .dn_valid  (s1_valid),
        .dn_ready  (s1_ready),
        .dn_data   (s1_data)
    );

    assign {s1_d, s1_h, s1_enc, s1_m} = s1_data;

    // Flips land after overall parity so the decoder sees a genuine codeword error.
    always_comb begin
        frame = FW'(s1_d);
        frame[DATA_W + ECC_HAM_OFS +: P] = s1_enc ? s1_h : '0;
        frame[DATA_W + ECC_HAM_OFS + P] = s1_enc && (^s1_d ^ ^s1_h);
        frame[FW - ECC_FLAG_FROM_TOP] = s1_enc;
        frame = frame ^ FW'(s1_m);
    end

    ecc_pipe_stage #(.W(FW)) u_s2 (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .up_valid  (s1_valid),
        .up_ready  (s1_ready),
        .up_data   (frame),
        .dn_valid  (o_wvalid),
        .dn_ready  (i_wready),
        .dn_data   (o_wdata)
    );

    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            inj_armed  <= 1'b0;
            inj_mode_q <= INJ_NONE;
            inj_pos_q  <= '0;
            beat_cnt   <= '0;
        end else begin
            if (i_inj_req && (i_inj_mode == INJ_SINGLE || i_inj_mode == INJ_DOUBLE)) begin
                inj_armed  <= 1'b1;
                inj_mode_q <= inj_mode_e'(i_inj_mode);
                inj_pos_q  <= i_inj_pos;
            end else if (accept && inject) begin
                inj_armed <= 1'b0;
            end
            if (o_wvalid && i_wready) beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign o_inj_armed = inj_armed;
    assign o_beat_cnt  = beat_cnt;

endmodule

// File: tb/tb_ecc_secded_encode_pipe.sv
// tb_ecc_secded_encode_pipe: directed and random checks against a syndrome-based frame model.
module tb_ecc_secded_encode_pipe;

    logic        i_aclk = 1'b0;
    logic        i_aresetn = 1'b0;
    logic        i_enable_ecc = 1'b0;
    logic        i_wvalid = 1'b0;
    logic        i_wready = 1'b0;
    logic        i_inj_req = 1'b0;
    logic [31:0] i_wdata = '0;
    logic [1:0]  i_inj_mode = '0;
    logic [5:0]  i_inj_pos = '0;
    logic        o_wready;
    logic        o_wvalid;
    logic        o_inj_armed;
    logic [39:0] o_wdata;
    logic [15:0] o_beat_cnt;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [39:0] exp_q[$];
    int          t_q[$];
    logic        m_armed = 1'b0;
    logic [1:0]  m_md = '0;
    logic [5:0]  m_ps = '0;
    logic [15:0] m_cnt = '0;

    always #5 i_aclk = ~i_aclk;

    ecc_secded_encode_pipe #(.DATA_W(32), .ECC_W(8), .CNT_W(16)) dut (
        .i_aclk       (i_aclk),
        .i_aresetn    (i_aresetn),
        .i_enable_ecc (i_enable_ecc),
        .i_wvalid     (i_wvalid),
        .o_wready     (o_wready),
        .i_wdata      (i_wdata),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_wdata      (o_wdata),
        .i_inj_req    (i_inj_req),
        .i_inj_mode   (i_inj_mode),
        .i_inj_pos    (i_inj_pos),
        .o_inj_armed  (o_inj_armed),
        .o_beat_cnt   (o_beat_cnt)
    );

    // Hamming bits equal the XOR of the codeword positions of all set data bits.
    function automatic logic [39:0] model(input logic [31:0] d, input logic en, input logic [1:0] md, input logic [5:0] ps);
        logic [39:0] f;
        int syn;
        int pos;
        int p;
        if (!en) return {8'h00, d};
        syn = 0;
        pos = 2;
        for (int i = 0; i < 32; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[i]) syn = syn ^ pos;
        end
        f = {1'b1, ^d ^ ^syn[5:0], syn[5:0], d};
        p = int'(ps) % 39;
        if (md == 2'd1 || md == 2'd2) f[p] = ~f[p];
        if (md == 2'd2) f[(p + 1) % 39] = ~f[(p + 1) % 39];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic en, input logic rdy,
                         input logic req, input logic [1:0] md, input logic [5:0] ps);
        logic exp_v;
        logic exp_rdy;
        logic inj;
        exp_v = exp_q.size() > 0 && cyc - t_q[0] >= 2;
        chk("inj_armed", 40'(o_inj_armed), 40'(m_armed));
        chk("beat_cnt", 40'(o_beat_cnt), 40'(m_cnt));
        chk("wvalid", 40'(o_wvalid), 40'(exp_v));
        if (exp_v) chk("wdata", o_wdata, exp_q[0]);
        i_wvalid = v;
        i_wdata = d;
        i_enable_ecc = en;
        i_wready = rdy;
        i_inj_req = req;
        i_inj_mode = md;
        i_inj_pos = ps;
        #1;
        exp_rdy = exp_q.size() < 2 || rdy;
        chk("wready", 40'(o_wready), 40'(exp_rdy));
        if (exp_v && rdy) begin
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
            m_cnt++;
        end
        if (v && exp_rdy) begin
            inj = m_armed && en;
            exp_q.push_back(model(d, en, inj ? m_md : 2'd0, m_ps));
            t_q.push_back(cyc);
            if (inj) m_armed = 1'b0;
        end
        if (req && (md == 2'd1 || md == 2'd2)) begin
            m_armed = 1'b1;
            m_md = md;
            m_ps = ps;
        end
        @(posedge i_aclk);
        cyc++;
        @(negedge i_aclk);
    endtask

    task automatic beat(input logic [31:0] d, input logic en);
        cycle(1'b1, d, en, 1'b1, 1'b0, 2'd0, 6'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0);
    endtask

    task automatic arm(input logic [1:0] md, input logic [5:0] ps);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, md, ps);
    endtask

    task automatic reset_dut();
        i_aresetn = 1'b0;
        i_wvalid = 1'b0;
        i_wready = 1'b0;
        i_inj_req = 1'b0;
        @(posedge i_aclk);
        cyc++;
        @(negedge i_aclk);
        i_aresetn = 1'b1;
        exp_q.delete();
        t_q.delete();
        m_armed = 1'b0;
        m_cnt = '0;
        chk("rst_wvalid", 40'(o_wvalid), 40'd0);
        chk("rst_wdata", o_wdata, 40'h0);
        chk("rst_armed", 40'(o_inj_armed), 40'd0);
        chk("rst_cnt", 40'(o_beat_cnt), 40'd0);
    endtask

    initial begin
        @(negedge i_aclk);
        reset_dut();
        beat(32'h0, 1'b1);
        idle();
        chk("t1_frame", o_wdata, 40'h80_0000_0000);
        idle();
        chk("t1_cnt", 40'(o_beat_cnt), 40'd1);
        beat(32'h1, 1'b1);
        idle();
        chk("t2_frame", o_wdata, 40'hC3_0000_0001);
        idle();
        beat(32'h1, 1'b0);
        idle();
        chk("t3_bypass", o_wdata, 40'h00_0000_0001);
        idle();
        arm(2'd1, 6'd0);
        chk("t4_armed", 40'(o_inj_armed), 40'd1);
        beat(32'h0, 1'b1);
        chk("t4_disarm", 40'(o_inj_armed), 40'd0);
        idle();
        chk("t4_single", o_wdata, 40'h80_0000_0001);
        beat(32'h0, 1'b1);
        idle();
        chk("t4_clean", o_wdata, 40'h80_0000_0000);
        idle();
        arm(2'd2, 6'd38);
        beat(32'h0, 1'b1);
        idle();
        chk("t4_double", o_wdata, 40'hC0_0000_0001);
        idle();
        arm(2'd1, 6'd5);
        beat(32'h1, 1'b0);
        chk("t4_bypass_keeps", 40'(o_inj_armed), 40'd1);
        cycle(1'b1, 32'hA5A5_0F0F, 1'b1, 1'b1, 1'b1, 2'd1, 6'd45);
        chk("t4_rearm", 40'(o_inj_armed), 40'd1);
        beat(32'hFFFF_FFFF, 1'b1);
        idle();
        idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'd3, 6'd2);
        chk("t4_reserved", 40'(o_inj_armed), 40'd0);
        idle();

        reset_dut();
        cycle(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
        cycle(1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
        chk("t5_ready_low", 40'(o_wready), 40'd0);
        cycle(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
        cycle(1'b1, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
        cycle(1'b1, 32'h4444_4444, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
        idle();
        idle();
        idle();
        chk("t5_cnt", 40'(o_beat_cnt), 40'd4);

        beat(32'h0000_1234, 1'b1);
        cycle(1'b1, 32'h0000_5678, 1'b1, 1'b1, 1'b1, 2'd2, 6'd10);
        reset_dut();
        beat(32'h1, 1'b1);
        idle();
        chk("t6_clean", o_wdata, 40'hC3_0000_0001);
        idle();

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        end
        for (int i = 0; i < 4; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_secded_encode_pipe.md
Name: ecc_secded_encode_pipe

Overview:
Parametrised SECDED (extended Hamming) encoder for the NoC link layer, sitting between the switching logic and the link serializer. It is the successor to the fixed 32-bit encoder, adding:
- a true per-bit Hamming code and an overall parity bit;
- a 2-stage valid/ready pipeline with backpressure;
- an ECC bypass mode;
- one-shot single/double error injection for decoder and HARQ verification.

Parameters:
DATA_W, 32, payload width in bits (8..64)
ECC_W, 8, ECC field width; must satisfy ECC_W >= P+2, where P = Hamming parity count (6 for DATA_W=32)
CNT_W, 16, width of the accepted-beat counter

Ports:
i_aclk  in  1  clock
i_aresetn  in  1  synchronous active-low reset
i_enable_ecc  in  1  1 = encode, 0 = bypass (ECC field all zero); sampled per beat at acceptance
i_wvalid  in  1  input beat valid
o_wready  out  1  input beat accepted when i_wvalid & o_wready
i_wdata  in  DATA_W  payload
o_wvalid  out  1  output frame valid
i_wready  in  1  downstream ready
o_wdata  out  DATA_W+ECC_W  frame = {flag, pad, overall, hamming[P-1:0], data}
i_inj_req  in  1  pulse: arm error injection
i_inj_mode  in  2  0 none, 1 single-bit, 2 double-bit, 3 reserved (treated as none)
i_inj_pos  in  clog2(DATA_W+P+1)  codeword bit index to flip
o_inj_armed  out  1  injection armed and not yet applied
o_beat_cnt  out  CNT_W  count of frames accepted downstream, wrapping

Behaviour:
Reset and timing:
- Reset (synchronous, i_aresetn=0 at posedge i_aclk): o_wvalid=0, o_wdata=0, o_inj_armed=0, o_beat_cnt=0, all stage valids 0. o_wready=1 in the cycle after reset.
- A reset mid-operation discards in-flight beats and any armed injection.
- Latency: 2 cycles from acceptance to o_wvalid with no stall.

Code definition:
- P = smallest integer with 2^P >= DATA_W+P+1.
- Codeword positions run 1..DATA_W+P. Parity bits occupy the power-of-2 positions. data[0] maps to position 3, and the remaining data bits fill the non-power-of-2 positions in ascending order.
- hamming[k] = XOR of the data bits whose position has bit k set.
- overall = XOR of all data bits and all hamming bits.

Frame layout:
- Bits [DATA_W-1:0] = data.
- Bits [DATA_W+P-1:DATA_W] = hamming.
- Bit DATA_W+P = overall.
- Bits above overall, up to DATA_W+ECC_W-2, = 0.
- Bit DATA_W+ECC_W-1 = flag, set to 1 when encoded.
- Bypass: the whole ECC field is 0 (flag 0); data passes unchanged.

Pipeline:
- Stage 1 registers data, hamming, mode and inject mask. Stage 2 adds overall parity and drives o_wdata.
- A stage advances when its successor is empty or advancing.
- o_wready = !s1_valid | s1_advance; this is a combinational ready path.
- o_wdata and o_wvalid hold stable while o_wvalid & !i_wready.
- Full throughput of 1 beat per cycle when i_wready is held at 1.

Error injection:
- i_inj_req with mode 1 or 2 sets o_inj_armed and latches mode and position. A request while already armed overwrites the latched values.
- The injection applies to the next accepted beat, only when that beat is encoded (i_enable_ecc=1). A bypass beat leaves it armed.
- o_inj_armed clears in the cycle after application. If i_inj_req coincides with an accepting beat, the new request applies to the following beat.
- Flips are applied after ECC computation, to frame bits with the same index as codeword bits 0..DATA_W+P.
- Single mode flips bit pos. Double mode flips pos and (pos+1) mod (DATA_W+P+1).
- pos > DATA_W+P is treated as pos mod (DATA_W+P+1).

Counter:
- o_beat_cnt increments on each o_wvalid & i_wready and wraps at 2^CNT_W.

Decomposition:
Package ecc_pkg holds:
- function ecc_parity_count(DATA_W) returning P;
- function ecc_hamming_gen(data) returning hamming bits;
- localparam frame-field offsets;
- enum inj_mode_e {INJ_NONE, INJ_SINGLE, INJ_DOUBLE}.

One sub-module, ecc_pipe_stage, is natural: a generic valid/ready register slice with parameter width, instantiated twice.

Test Plan:
1. Reset then data 0x00000000 with ECC enabled -> after 2 cycles o_wdata=0x80_0000_0000, o_beat_cnt=1.
2. Data 0x00000001 with ECC enabled -> o_wdata=0xC3_0000_0001 (hamming bits 0 and 1, overall bit 38, flag bit 39).
3. Data 0x00000001 with i_enable_ecc=0 -> o_wdata=0x00_0000_0001.
4. Arm single injection at pos 0, then send data 0x00000000 -> o_wdata=0x80_0000_0001 and o_inj_armed clears. Next beat 0x00000000 -> 0x80_0000_0000. Repeat with double injection at pos 38 -> bits 38 and 0 flip, giving 0xC0_0000_0001.
5. Backpressure: 4 back-to-back beats with i_wready=0 for 3 cycles -> o_wready drops after 2 beats are accepted, o_wdata stays stable while stalled, frames emerge in order, o_beat_cnt=4.
6. Reset asserted while 2 beats are in flight and an injection is armed -> next cycle o_wvalid=0, o_wdata=0, o_inj_armed=0, o_beat_cnt=0; the following frame is clean.
